pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding,
// lock-loss filter length and the cycle-counter width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  localparam int LOSS_FILTER_LEN = 4;

  // Bits needed to count 0 .. max-1 for the largest of the supplied spans.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock indication into
// the refclk domain; both flops clear on the synchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable lock, then releases
// domain resets one by one. Define PLL_SEQ_LOSS_FILTER_EN to ignore short dropouts.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CLKS            = 5,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 74250,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic [NUM_CLKS-1:0] domain_rst,
  output logic                ready,
  output logic [7:0]          relock_count,
  output logic                timeout_err
);

  localparam int REL_SPAN = (NUM_CLKS - 1) * STAGGER_CYCLES;
  localparam int CNT_W    = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                      LOCK_STABLE_CYCLES, REL_SPAN + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_SPAN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic             timeout_q, timeout_d;
  logic             locked_s;
  logic             live;
  logic             loss_act;
  logic             relock_evt;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign live = (state_q == S_RELEASE) || (state_q == S_RUN);

`ifdef PLL_SEQ_LOSS_FILTER_EN
  localparam int LOW_W = $clog2(LOSS_FILTER_LEN);

  logic [LOW_W-1:0] low_q, low_d;

  // Loss is acted on only on the Nth consecutive unlocked cycle.
  assign loss_act = live && !locked_s && (low_q == LOW_W'(LOSS_FILTER_LEN - 1));
  assign low_d    = (live && !locked_s && !loss_act) ? low_q + LOW_W'(1) : '0;

  always_ff @(posedge refclk) begin
    if (rst) low_q <= '0;
    else     low_q <= low_d;
  end
`else
  assign loss_act = live && !locked_s;
`endif

  // Lock loss and a forced relock in the same cycle are one event.
  assign relock_evt = loss_act || (force_relock && (state_q != S_PLL_RST));

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      relock_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    relock_d  = relock_q;
    timeout_d = timeout_q;
    if (relock_evt) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end
        end
        S_RELEASE: begin
          if (cnt_q == REL_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN:   cnt_d = '0;
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A loss event forces every domain back into reset in the cycle it is seen.
  always_comb begin
    pll_rst    = (state_q == S_PLL_RST);
    ready      = 1'b0;
    domain_rst = '1;
    case (state_q)
      S_RELEASE: begin
        if (!relock_evt) begin
          for (int k = 0; k < NUM_CLKS; k++) begin
            domain_rst[k] = (cnt_q < CNT_W'(k * STAGGER_CYCLES));
          end
        end
      end
      S_RUN: begin
        if (!relock_evt) begin
          ready      = 1'b1;
          domain_rst = '0;
        end
      end
      default: ;
    endcase
  end

  assign relock_count = relock_q;
  assign timeout_err  = timeout_q;

endmodule
